dmx_rx: RTL and testbench



---
 rtl/dmx_rx.sv | 261 ++++++++++++++++++++++++++
 tb/tb_dmx_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dmx_rx.sv
// DMX512 receiver: decodes break/MAB/slot framing from the raw line and packs
// slot pairs into 16-bit words issued as single-cycle writes on the output bus.
module dmx_rx #(
   parameter int         CLOCKS_PER_BIT    = 96,
   parameter int         BREAK_MIN_CLOCKS  = 2112,
   parameter int         ADDRESS_BUS_WIDTH = 13,
   parameter int         BASE_ADDRESS      = 0,
   parameter logic [7:0] START_CODE        = 8'h00,
   parameter int         MAX_SLOTS         = 512
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         dmx_in,
   output logic [15:0]                  data,
   output logic [ADDRESS_BUS_WIDTH:0]   address,
   output logic                         write_strobe,
   output logic                         frame_done,
   output logic                         frame_error,
   output logic [9:0]                   slot_count
);

   localparam int AW     = ADDRESS_BUS_WIDTH + 1;
   localparam int HALF   = CLOCKS_PER_BIT / 2;
   localparam int BIT_W  = $clog2(CLOCKS_PER_BIT);
   localparam int BRK_W  = $clog2(BREAK_MIN_CLOCKS + 10 * CLOCKS_PER_BIT + 1);

   localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(CLOCKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] HALF_LAST   = BIT_W'(HALF - 1);
   localparam logic [BRK_W-1:0] BRK_MIN     = BRK_W'(BREAK_MIN_CLOCKS);
   localparam logic [BRK_W-1:0] BRK_PRELOAD = BRK_W'(10 * CLOCKS_PER_BIT - HALF);
   localparam logic [9:0]       SLOT_LAST   = 10'(MAX_SLOTS - 1);
   localparam logic [AW-1:0]    BASE        = AW'(BASE_ADDRESS);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_BREAK      = 3'd1;
   localparam logic [2:0] S_MAB        = 3'd2;
   localparam logic [2:0] S_START_BIT  = 3'd3;
   localparam logic [2:0] S_DATA_BITS  = 3'd4;
   localparam logic [2:0] S_STOP_BIT   = 3'd5;
   localparam logic [2:0] S_WAIT_START = 3'd6;

   // NOTE: reset asserts asynchronously but leaves on a clock edge, so no flop
   // sees its reset removed in the middle of a setup window.
   logic [1:0] rst_pipe_q, rst_pipe_d;
   logic       core_rst;

   always_comb rst_pipe_d = {rst_pipe_q[0], 1'b0};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rst_pipe_q <= 2'b11;
      else     rst_pipe_q <= rst_pipe_d;
   end

   assign core_rst = rst_pipe_q[1];

   // Two synchroniser stages plus one history stage for falling-edge detect.
   logic [2:0] dmx_pipe_q, dmx_pipe_d;
   logic       dmx_s, dmx_fall;

   always_comb dmx_pipe_d = {dmx_pipe_q[1:0], dmx_in};
   assign dmx_s    = dmx_pipe_q[1];
   assign dmx_fall = dmx_pipe_q[2] & ~dmx_pipe_q[1];

   logic [2:0]       state_q, state_d;
   logic [BRK_W-1:0] brk_cnt_q, brk_cnt_d;
   logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       high_q, high_d;
   logic [9:0]       slot_cnt_q, slot_cnt_d;
   logic             start_pending_q, start_pending_d;
   logic             active_q, active_d;
   logic             done_pend_q, done_pend_d;
   logic [15:0]      data_q, data_d;
   logic [AW-1:0]    address_q, address_d;
   logic             write_strobe_q, write_strobe_d;
   logic             frame_done_q, frame_done_d;
   logic             frame_error_q, frame_error_d;
   logic [9:0]       slot_count_q, slot_count_d;

   always_comb begin
      // NOTE: every target gets a default first so no path infers a latch.
      state_d         = state_q;
      brk_cnt_d       = brk_cnt_q;
      bit_cnt_d       = bit_cnt_q;
      bit_idx_d       = bit_idx_q;
      shift_d         = shift_q;
      high_d          = high_q;
      slot_cnt_d      = slot_cnt_q;
      start_pending_d = start_pending_q;
      active_d        = active_q;
      done_pend_d     = 1'b0;
      data_d          = data_q;
      address_d       = address_q;
      write_strobe_d  = 1'b0;
      frame_done_d    = 1'b0;
      frame_error_d   = 1'b0;
      slot_count_d    = slot_count_q;

      if (done_pend_q) begin
         frame_done_d = 1'b1;
         slot_count_d = slot_cnt_q;
      end

      case (state_q)
         S_IDLE: begin
            start_pending_d = 1'b0;
            active_d        = 1'b0;
            if (!dmx_s) begin
               state_d   = S_BREAK;
               brk_cnt_d = '0;
            end
         end

         S_BREAK: begin
            if (dmx_s) begin
               if (brk_cnt_q >= BRK_MIN) begin
                  state_d         = S_MAB;
                  start_pending_d = 1'b1;
               end else begin
                  state_d       = S_IDLE;
                  frame_error_d = 1'b1;
               end
            end else if (brk_cnt_q < BRK_MIN) begin
               brk_cnt_d = brk_cnt_q + 1'b1;
            end
         end

         S_MAB, S_WAIT_START: begin
            if (dmx_fall) begin
               state_d   = S_START_BIT;
               bit_cnt_d = '0;
            end
         end

         S_START_BIT: begin
            if (bit_cnt_q == HALF_LAST) begin
               bit_cnt_d = '0;
               bit_idx_d = '0;
               if (dmx_s) state_d = start_pending_q ? S_MAB : S_WAIT_START;
               else       state_d = S_DATA_BITS;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end

         S_DATA_BITS: begin
            if (bit_cnt_q == BIT_LAST) begin
               bit_cnt_d = '0;
               shift_d   = {dmx_s, shift_q[7:1]};
               if (bit_idx_q == 3'd7) state_d = S_STOP_BIT;
               else                   bit_idx_d = bit_idx_q + 1'b1;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end

         S_STOP_BIT: begin
            if (bit_cnt_q != BIT_LAST) begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end else begin
               bit_cnt_d = '0;
               if (dmx_s) begin
                  state_d = S_WAIT_START;
                  if (start_pending_q) begin
                     start_pending_d = 1'b0;
                     if (shift_q == START_CODE) begin
                        active_d   = 1'b1;
                        slot_cnt_d = '0;
                     end else begin
                        state_d = S_IDLE;
                     end
                  end else if (active_q) begin
                     if (!slot_cnt_q[0]) begin
                        high_d = shift_q;
                     end else begin
                        write_strobe_d = 1'b1;
                        data_d         = {high_q, shift_q};
                        address_d      = BASE + AW'(slot_cnt_q >> 1);
                     end
                     slot_cnt_d = slot_cnt_q + 10'd1;
                     if (slot_cnt_q == SLOT_LAST) begin
                        active_d    = 1'b0;
                        done_pend_d = 1'b1;
                     end
                  end
               end else if (shift_q == 8'h00) begin
                  // A zero byte with a low stop bit is the next break, already
                  // one character long.
                  state_d         = S_BREAK;
                  brk_cnt_d       = BRK_PRELOAD;
                  start_pending_d = 1'b0;
                  active_d        = 1'b0;
                  if (active_q && slot_cnt_q != 10'd0) begin
                     done_pend_d = 1'b1;
                     if (slot_cnt_q[0]) begin
                        write_strobe_d = 1'b1;
                        data_d         = {high_q, 8'h00};
                        address_d      = BASE + AW'(slot_cnt_q >> 1);
                     end
                  end
               end else begin
                  state_d       = S_IDLE;
                  frame_error_d = 1'b1;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state is only ever written with non-blocking assignments.
   always_ff @(posedge clk or posedge core_rst) begin
      if (core_rst) begin
         dmx_pipe_q      <= 3'b111;
         state_q         <= S_IDLE;
         brk_cnt_q       <= '0;
         bit_cnt_q       <= '0;
         bit_idx_q       <= '0;
         shift_q         <= '0;
         high_q          <= '0;
         slot_cnt_q      <= '0;
         start_pending_q <= 1'b0;
         active_q        <= 1'b0;
         done_pend_q     <= 1'b0;
         data_q          <= '0;
         address_q       <= '0;
         write_strobe_q  <= 1'b0;
         frame_done_q    <= 1'b0;
         frame_error_q   <= 1'b0;
         slot_count_q    <= '0;
      end else begin
         dmx_pipe_q      <= dmx_pipe_d;
         state_q         <= state_d;
         brk_cnt_q       <= brk_cnt_d;
         bit_cnt_q       <= bit_cnt_d;
         bit_idx_q       <= bit_idx_d;
         shift_q         <= shift_d;
         high_q          <= high_d;
         slot_cnt_q      <= slot_cnt_d;
         start_pending_q <= start_pending_d;
         active_q        <= active_d;
         done_pend_q     <= done_pend_d;
         data_q          <= data_d;
         address_q       <= address_d;
         write_strobe_q  <= write_strobe_d;
         frame_done_q    <= frame_done_d;
         frame_error_q   <= frame_error_d;
         slot_count_q    <= slot_count_d;
      end
   end

   assign data         = data_q;
   assign address      = address_q;
   assign write_strobe = write_strobe_q;
   assign frame_done   = frame_done_q;
   assign frame_error  = frame_error_q;
   assign slot_count   = slot_count_q;

endmodule

// File: tb/tb_dmx_rx.sv
// Directed bench for dmx_rx at a scaled bit rate; writes and packet ends are
// checked against scoreboard queues filled as the stimulus is driven.
module tb_dmx_rx;

   localparam int CPB     = 10;
   localparam int BRK_MIN = 220;
   localparam int BRK_LEN = 240;
   localparam int MAB_LEN = 30;

   logic        clk = 1'b0;
   logic        rst;
   logic        dmx_in;
   logic [15:0] data;
   logic [13:0] address;
   logic        write_strobe;
   logic        frame_done;
   logic        frame_error;
   logic [9:0]  slot_count;

   dmx_rx #(
      .CLOCKS_PER_BIT   (CPB),
      .BREAK_MIN_CLOCKS (BRK_MIN)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .dmx_in       (dmx_in),
      .data         (data),
      .address      (address),
      .write_strobe (write_strobe),
      .frame_done   (frame_done),
      .frame_error  (frame_error),
      .slot_count   (slot_count)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;
   int err_cnt    = 0;
   int cyc        = 0;
   int last_strb  = -100;

   logic [29:0] exp_wr[$];    // {address, data}
   logic [10:0] exp_done[$];  // {follows_strobe, slot_count}

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (frame_error === 1'b1) err_cnt++;
      if (write_strobe === 1'b1) begin
         last_strb = cyc;
         check("strobe_expected", 64'(exp_wr.size() > 0), 64'd1);
         if (exp_wr.size() > 0) check("wr_addr_data", 64'({address, data}), 64'(exp_wr.pop_front()));
      end
      if (frame_done === 1'b1) begin
         check("done_expected", 64'(exp_done.size() > 0), 64'd1);
         if (exp_done.size() > 0) begin
            logic [10:0] e;
            e = exp_done.pop_front();
            check("slot_count", 64'(slot_count), 64'(e[9:0]));
            if (e[10]) check("done_after_strobe", 64'(cyc - last_strb), 64'd1);
         end
      end
   end

   task automatic line(input logic v, input int n);
      dmx_in = v;
      repeat (n) @(posedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      line(1'b0, CPB);
      for (int i = 0; i < 8; i++) line(b[i], CPB);
      line(1'b1, CPB);
   endtask

   task automatic send_header(input logic [7:0] sc);
      line(1'b0, BRK_LEN);
      line(1'b1, MAB_LEN);
      send_byte(sc);
   endtask

   task automatic end_packet();
      line(1'b0, BRK_LEN);
      line(1'b1, MAB_LEN);
      line(1'b1, 20);
   endtask

   task automatic check_drained(input string tag);
      check({tag, "_wr_left"}, 64'(exp_wr.size()), 64'd0);
      check({tag, "_done_left"}, 64'(exp_done.size()), 64'd0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_data"}, 64'(data), 64'd0);
      check({tag, "_address"}, 64'(address), 64'd0);
      check({tag, "_strobe"}, 64'(write_strobe), 64'd0);
      check({tag, "_done"}, 64'(frame_done), 64'd0);
      check({tag, "_error"}, 64'(frame_error), 64'd0);
      check({tag, "_slot_count"}, 64'(slot_count), 64'd0);
   endtask

   initial begin
      int err_snap;
      rst    = 1'b1;
      dmx_in = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b0;
      repeat (10) @(posedge clk);

      // Short low pulse in IDLE: one framing error, then a normal packet.
      line(1'b1, 20);
      line(1'b0, 150);
      line(1'b1, 30);
      check("short_break_err", 64'(err_cnt), 64'd1);

      err_snap = err_cnt;
      exp_wr.push_back({14'd0, 16'h1234});
      exp_wr.push_back({14'd1, 16'h5678});
      exp_done.push_back({1'b0, 10'd4});
      send_header(8'h00);
      send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
      end_packet();
      check_drained("basic");
      check("basic_no_err", 64'(err_cnt), 64'(err_snap));

      // Wrong start code: whole packet ignored.
      send_header(8'hCC);
      send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
      end_packet();
      check_drained("bad_start");

      // Odd slot count: last even slot flushed with a zero low byte.
      exp_wr.push_back({14'd0, 16'hAABB});
      exp_wr.push_back({14'd1, 16'hCC00});
      exp_done.push_back({1'b1, 10'd3});
      send_header(8'h00);
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
      end_packet();
      check_drained("odd_slots");

      // Short glitch while waiting for a start bit decodes nothing.
      err_snap = err_cnt;
      exp_wr.push_back({14'd0, 16'h1122});
      exp_wr.push_back({14'd1, 16'h3344});
      exp_done.push_back({1'b0, 10'd4});
      send_header(8'h00);
      send_byte(8'h11); send_byte(8'h22);
      line(1'b0, 3);
      line(1'b1, 50);
      send_byte(8'h33); send_byte(8'h44);
      end_packet();
      check_drained("glitch");
      check("glitch_no_err", 64'(err_cnt), 64'(err_snap));

      // Full packet plus one extra byte that must be ignored.
      for (int p = 0; p < 256; p++)
         exp_wr.push_back({14'(p), 8'(2 * p), 8'(2 * p + 1)});
      exp_done.push_back({1'b1, 10'd512});
      send_header(8'h00);
      for (int s = 0; s < 512; s++) send_byte(8'(s));
      check("full_last_addr", 64'(address), 64'd255);
      check("full_last_data", 64'(data), 64'hFEFF);
      send_byte(8'h5A);
      end_packet();
      check_drained("full");
      check("full_slot_count", 64'(slot_count), 64'd512);

      // Reset in the middle of slot 5: pair 2 never written.
      exp_wr.push_back({14'd0, 16'h0102});
      exp_wr.push_back({14'd1, 16'h0304});
      send_header(8'h00);
      for (int s = 1; s <= 5; s++) send_byte(8'(s));
      line(1'b0, CPB);
      line(1'b1, CPB);
      line(1'b0, 5);
      #2 rst = 1'b1;
      #1 check_outputs_zero("async_rst");
      dmx_in = 1'b1;
      repeat (5) @(posedge clk);
      #2 rst = 1'b0;
      repeat (10) @(posedge clk);
      check_drained("rst_partial");
      exp_wr.push_back({14'd0, 16'h9ABC});
      exp_done.push_back({1'b0, 10'd2});
      send_header(8'h00);
      send_byte(8'h9A); send_byte(8'hBC);
      end_packet();
      check_drained("after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
